dice_roller: RTL and testbench
==============================

# dice_roller

Sequencing controller for the nine-segment LED dice decoder. It turns a debounced push-button into an animated dice roll. While rolling, it steps the 3-bit face code `s` through 1..MAX_FACE with a linearly slowing step period, then settles on a final face that depends on press timing. `s` connects directly to the decoder's 3-bit select input.

## Interface
- MAX_FACE, 6: highest face value; legal range 1..7; faces cycle 1..MAX_FACE.
- NUM_STEPS, 8: minimum number of face advances per roll; must be ≥1.
- TICK_DIV, 2_500_000: length of the first step in clk cycles; must be ≥1.
- TICK_INC, 500_000: cycles added to each successive step period; must be ≥0.
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- roll  input  1  debounced push-button level, synchronous to clk.
- s  output  3  face code to the decoder; 0 = blank.
- rolling  output  1  high while a roll is in progress.
- done  output  1  one-cycle pulse when a roll completes.

## Operation
- States: IDLE, ROLL.
- Seed counter:
  - free-running, counts 0..MAX_FACE-1 and wraps to 0;
  - advances every cycle in all states; reset value 0.
- Edge detect:
  - roll_q is a registered copy of roll; it resets to 1, so a button held through reset does not start a roll;
  - start = roll & ~roll_q & (state == IDLE).
- IDLE:
  - s holds the last result (0 after reset);
  - on start, capture steps_left = NUM_STEPS + seed, where seed is the counter value in the start cycle;
  - clear step index k and tick counter;
  - if s == 0, load s = 1; otherwise keep s;
  - go to ROLL.
- ROLL:
  - the tick counter increments each cycle;
  - when tick == TICK_DIV + k*TICK_INC − 1, advance s (MAX_FACE wraps to 1), clear tick, increment k, decrement steps_left.
  - The advance with steps_left == 1 is the final one. At that edge: go to IDLE, assert done for exactly one cycle, and deassert rolling.
- roll edges during ROLL are ignored; they are not queued. A new roll needs a fresh rising edge observed in IDLE.
- Widths:
  - tick counter ≥ ceil(log2(TICK_DIV + (NUM_STEPS+MAX_FACE)*TICK_INC));
  - steps_left ≥ ceil(log2(NUM_STEPS+MAX_FACE));
  - all arithmetic is unsigned with no overflow under legal parameters.
- s is always in 0..MAX_FACE. With MAX_FACE = 1, s stays 1 for every step.

## Timing
- Reset values: s = 0, rolling = 0, done = 0, state IDLE, seed = 0, roll_q = 1, tick = 0, k = 0.
- A reset asserted mid-roll aborts the roll on that edge: outputs return to reset values and no done pulse is produced.
- The start edge registers rolling = 1 and the possible s = 1 load.
- Step k lasts TICK_DIV + k*TICK_INC cycles.
- With N = NUM_STEPS + seed, the final advance occurs Σ_{k=0}^{N−1}(TICK_DIV + k*TICK_INC) edges after the start edge; done is high the cycle after that edge.
- Final face: ((s_start − 1 + N) mod MAX_FACE) + 1, where s_start is the value of s after the start edge.
- All outputs are registered; there is no combinational path from roll to any output.
- The earliest new start is the cycle after done, if roll is low→high at that point.

## Test plan
- Reset, then hold reset 3 cycles with roll = 1 → s = 0, rolling = 0, done = 0; after release, roll held high starts no roll for 20 cycles.
- Parameters MAX_FACE=6, NUM_STEPS=4, TICK_DIV=2, TICK_INC=1; rising roll sampled with seed = 2, s = 0 → s = 1 at the start edge, then 2,3,4,5,6,1 at +2,+5,+9,+14,+20,+27 edges; done pulses once; rolling falls at +27; final s = 1.
- Same parameters, s = 5, seed = 0 → s becomes 6,1,2,3 at +2,+5,+9,+14; done once; final s = 3.
- Press again three times during a roll, plus roll held high for 100 cycles → exactly one roll and one done; no second roll until roll goes low then high in IDLE.
- Assert reset at the 10th cycle of a roll → next cycle s = 0, rolling = 0, done stays 0; a later press rolls normally from s = 0.
- MAX_FACE=1, NUM_STEPS=3 → s stays 1 throughout; done after 3 steps with seed always 0; s never exceeds MAX_FACE in any test (assertion).

Source files
------------

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - button-driven animated dice roll sequencer for the LED dice decoder
//
// Ports:
//   clk      in   system clock, rising-edge
//   reset    in   synchronous active-high reset
//   roll     in   debounced push-button level
//   s        out  3-bit face code to the decoder (0 = blank)
//   rolling  out  high while a roll is in progress
//   done     out  one-cycle pulse when a roll completes

module dice_roller #(
  parameter int MAX_FACE  = 6,
  parameter int NUM_STEPS = 8,
  parameter int TICK_DIV  = 2_500_000,
  parameter int TICK_INC  = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  output logic [2:0] s,
  output logic       rolling,
  output logic       done
);

  localparam int MAX_PERIOD = TICK_DIV + (NUM_STEPS + MAX_FACE) * TICK_INC;
  localparam int TW = $clog2(MAX_PERIOD + 1);
  localparam int SW = $clog2(NUM_STEPS + MAX_FACE + 1);
  localparam int DW = $clog2(MAX_FACE + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROLL = 1'b1
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_seed;
  logic          r_roll_q;
  logic [2:0]    r_s;
  logic          r_done;
  logic [TW-1:0] r_tick;
  // Current step period; starts at TICK_DIV and grows by TICK_INC per advance,
  // which is TICK_DIV + k*TICK_INC without needing a multiplier.
  logic [TW-1:0] r_period;
  logic [SW-1:0] r_left;

  state_t        w_state_n;
  logic [DW-1:0] w_seed_n;
  logic [2:0]    w_s_n;
  logic          w_done_n;
  logic [TW-1:0] w_tick_n;
  logic [TW-1:0] w_period_n;
  logic [SW-1:0] w_left_n;
  logic          w_start;
  logic          w_last_tick;
  logic [2:0]    w_face_next;

  assign w_start     = roll & ~r_roll_q & (r_state == ST_IDLE);
  assign w_last_tick = (r_tick == r_period - TW'(1));
  assign w_face_next = (r_s == 3'(MAX_FACE)) ? 3'd1 : r_s + 3'd1;
  assign w_seed_n    = (r_seed == DW'(MAX_FACE - 1)) ? '0 : r_seed + DW'(1);

  always_comb begin
    w_state_n  = r_state;
    w_s_n      = r_s;
    w_done_n   = 1'b0;
    w_tick_n   = r_tick;
    w_period_n = r_period;
    w_left_n   = r_left;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_left_n   = SW'(NUM_STEPS) + SW'(r_seed);
          w_tick_n   = '0;
          w_period_n = TW'(TICK_DIV);
          if (r_s == 3'd0) w_s_n = 3'd1;
          w_state_n  = ST_ROLL;
        end
      end
      ST_ROLL: begin
        if (w_last_tick) begin
          w_s_n      = w_face_next;
          w_tick_n   = '0;
          w_period_n = r_period + TW'(TICK_INC);
          w_left_n   = r_left - SW'(1);
          if (r_left == SW'(1)) begin
            w_state_n = ST_IDLE;
            w_done_n  = 1'b1;
          end
        end else begin
          w_tick_n = r_tick + TW'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_seed   <= '0;
      r_roll_q <= 1'b1;   // a button held through reset must not look like a press
      r_s      <= 3'd0;
      r_done   <= 1'b0;
      r_tick   <= '0;
      r_period <= TW'(TICK_DIV);
      r_left   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_seed   <= w_seed_n;
      r_roll_q <= roll;
      r_s      <= w_s_n;
      r_done   <= w_done_n;
      r_tick   <= w_tick_n;
      r_period <= w_period_n;
      r_left   <= w_left_n;
    end
  end

  assign s       = r_s;
  assign done    = r_done;
  assign rolling = (r_state == ST_ROLL);

endmodule

// File: tb/tb_dice_roller.sv
// tb/tb_dice_roller.sv - scoreboard bench for dice_roller (6-face and 1-face instances)

module tb_dice_roller;

  typedef struct {
    int off;
    int face;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset0 = 1'b1, reset1 = 1'b1;
  logic       roll0 = 1'b1, roll1 = 1'b1;
  logic [2:0] s0, s1;
  logic       rolling0, rolling1, done0, done1;

  int   checks = 0;
  int   failures = 0;
  int   m_seed = 0;
  bit   armed = 1'b0;
  ev_t  q[$];

  always #5 clk = ~clk;

  dice_roller #(.MAX_FACE(6), .NUM_STEPS(4), .TICK_DIV(2), .TICK_INC(1)) dut0 (
    .clk(clk), .reset(reset0), .roll(roll0), .s(s0), .rolling(rolling0), .done(done0)
  );

  dice_roller #(.MAX_FACE(1), .NUM_STEPS(3), .TICK_DIV(2), .TICK_INC(1)) dut1 (
    .clk(clk), .reset(reset1), .roll(roll1), .s(s1), .rolling(rolling1), .done(done1)
  );

  // Independent model of the free-running seed counter of dut0
  always @(posedge clk) begin
    if (reset0) m_seed <= 0;
    else        m_seed <= (m_seed == 5) ? 0 : m_seed + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      assert (s0 <= 3'd6 && s1 <= 3'd1) else begin
        failures++;
        $error("FAIL s_range observed=%0d/%0d expected<=6/1", s0, s1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] f_s(input int sel);
    return (sel != 0) ? s1 : s0;
  endfunction

  function automatic logic f_rolling(input int sel);
    return (sel != 0) ? rolling1 : rolling0;
  endfunction

  function automatic logic f_done(input int sel);
    return (sel != 0) ? done1 : done0;
  endfunction

  task automatic drive_roll(input int sel, input logic v);
    if (sel != 0) roll1 = v;
    else          roll0 = v;
  endtask

  // mode 0: single press; mode 1: extra presses then held high; mode 2: reset at edge 10
  task automatic do_roll(input int sel, input int want_seed, input int mode);
    int  mf, ns, n, s_start, fin, off, exp_s, budget;
    bit  any;
    ev_t e;
    mf = (sel != 0) ? 1 : 6;
    ns = (sel != 0) ? 3 : 4;
    if (sel == 0) begin
      budget = 0;
      while (m_seed != want_seed && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("seed_wait", m_seed, want_seed);
    end
    s_start = (f_s(sel) == 3'd0) ? 1 : int'(f_s(sel));
    n   = ns + want_seed;
    off = 0;
    for (int i = 0; i < n; i++) begin
      off   += 2 + i;
      e.off  = off;
      e.face = ((s_start - 1 + i + 1) % mf) + 1;
      q.push_back(e);
    end
    fin = off;
    drive_roll(sel, 1'b1);
    @(negedge clk);
    exp_s = s_start;
    chk("start_s", f_s(sel), exp_s);
    chk("start_rolling", f_rolling(sel), 1);
    chk("start_done", f_done(sel), 0);
    drive_roll(sel, 1'b0);
    for (int j = 1; j <= fin + 1; j++) begin
      if (mode == 1) drive_roll(sel, (j >= 8) || (j % 2 == 0));
      if (mode == 2 && j == 10) begin
        reset0 = 1'b1;
        @(negedge clk);
        chk("abort_s", s0, 0);
        chk("abort_rolling", rolling0, 0);
        chk("abort_done", done0, 0);
        reset0 = 1'b0;
        q.delete();
        return;
      end
      @(negedge clk);
      if (q.size() > 0 && q[0].off == j) begin
        exp_s = q[0].face;
        void'(q.pop_front());
      end
      chk($sformatf("s@%0d", j), f_s(sel), exp_s);
      chk($sformatf("rolling@%0d", j), f_rolling(sel), (j < fin) ? 1 : 0);
      chk($sformatf("done@%0d", j), f_done(sel), (j == fin) ? 1 : 0);
    end
    chk("queue_empty", q.size(), 0);
    if (mode == 1) begin
      any = 1'b0;
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        if (f_rolling(sel) || f_done(sel)) any = 1'b1;
      end
      chk("held_no_reroll", any, 0);
      chk("held_s", f_s(sel), exp_s);
      drive_roll(sel, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit any;
    // Reset held three cycles with the button pressed
    repeat (3) @(negedge clk);
    armed = 1'b1;
    chk("rst_s", s0, 0);
    chk("rst_rolling", rolling0, 0);
    chk("rst_done", done0, 0);
    chk("rst_s1", s1, 0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    any = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (rolling0 || done0 || rolling1) any = 1'b1;
    end
    chk("held_through_reset", any, 0);
    roll0 = 1'b0;
    roll1 = 1'b0;
    @(negedge clk);

    do_roll(0, 2, 0);   // s 0 -> 1, six advances, ends on 1
    do_roll(0, 0, 0);   // 1 -> 5
    do_roll(0, 0, 0);   // 5 -> 6,1,2,3
    do_roll(0, 3, 1);   // presses during roll are ignored
    do_roll(0, 1, 0);
    do_roll(0, 4, 2);   // reset mid-roll
    chk("post_abort_s", s0, 0);
    do_roll(0, 1, 0);   // rolls normally from blank
    do_roll(1, 0, 0);   // single-face die
    do_roll(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
